// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared definitions for the RV32M multiply/divide unit.
//   XLEN            operand/result width (also the iteration count)
//   F3_MUL..F3_REMU M-extension func3 operation codes
//   F7_MULDIV       func7 code that marks an M-extension instruction
//   md_state_e      FSM state encodings
//   cond_neg()      two's-complement negate when the flag is set
package muldiv_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'b00,
    MD_CALC  = 2'b01,
    MD_FIXUP = 2'b10,
    MD_DONE  = 2'b11
  } md_state_e;

  // Shared by product, quotient and remainder sign correction.
  function automatic logic [2*XLEN-1:0] cond_neg(input logic [2*XLEN-1:0] v,
                                                 input logic              neg);
    return neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply / restoring divide on operand magnitudes, one bit per
// cycle for XLEN cycles, followed by a sign-fixup cycle.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  launch request, only honoured in IDLE
//   op     func3 operation select (MUL..REMU)
//   rs1    multiplicand / dividend, captured on accepted start
//   rs2    multiplier / divisor, captured on accepted start
//   flush  abort; returns to IDLE without done, result untouched
//   busy   high while the unit is not IDLE (stalls IF/ID/EX)
//   done   one-cycle pulse, result valid in the same cycle
//   result registered result, held until the next done
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_X    = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       op_r;
  // opd_r: multiplicand for multiply, divisor for divide.
  // lo_r : multiplier / low product half, or dividend shifting into quotient.
  // hi_r : high product half, or partial remainder.
  logic [XLEN-1:0]  opd_r, lo_r, hi_r;
  logic             neg_res_r, neg_rem_r;
  logic             busy_r, done_r;
  logic [XLEN-1:0]  result_r;

  logic             sign1_s, sign2_s, div_zero_s, ovf_s, special_s;
  logic [XLEN-1:0]  mag1_s, mag2_s;
  logic [XLEN:0]    mul_sum_s, shifted_s, diff_s;
  logic [2*XLEN-1:0] fix_in_s, fixed_s;
  logic             fix_neg_s;
  logic [XLEN-1:0]  fix_s;

  // Operand sign/magnitude decode and special-case detection for a launch.
  always_comb begin
    sign1_s = 1'b0;
    sign2_s = 1'b0;
    case (op)
      F3_MULH, F3_DIV, F3_REM: begin
        sign1_s = rs1[XLEN-1];
        sign2_s = rs2[XLEN-1];
      end
      F3_MULHSU: sign1_s = rs1[XLEN-1];
      default: begin
        sign1_s = 1'b0;
        sign2_s = 1'b0;
      end
    endcase
    mag1_s     = sign1_s ? (ZERO_X - rs1) : rs1;
    mag2_s     = sign2_s ? (ZERO_X - rs2) : rs2;
    div_zero_s = op[2] && (rs2 == ZERO_X);
    ovf_s      = ((op == F3_DIV) || (op == F3_REM)) && (rs1 == MIN_X) && (rs2 == ONES_X);
    special_s  = div_zero_s || ovf_s;
  end

  // One iteration step: shift-add for multiply, XLEN+1-bit trial subtract for divide.
  always_comb begin
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : {(XLEN+1){1'b0}});
    shifted_s = {hi_r, lo_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, opd_r};
  end

  // Sign fixup and output selection; one negator serves every operation.
  always_comb begin
    fix_in_s  = {hi_r, lo_r};
    fix_neg_s = neg_res_r;
    case (op_r)
      F3_DIV, F3_DIVU: begin
        fix_in_s  = {ZERO_X, lo_r};
        fix_neg_s = neg_res_r;
      end
      F3_REM, F3_REMU: begin
        fix_in_s  = {ZERO_X, hi_r};
        fix_neg_s = neg_rem_r;
      end
      default: begin
        fix_in_s  = {hi_r, lo_r};
        fix_neg_s = neg_res_r;
      end
    endcase
    fixed_s = cond_neg(fix_in_s, fix_neg_s);
    if ((op_r == F3_MULH) || (op_r == F3_MULHSU) || (op_r == F3_MULHU)) begin
      fix_s = fixed_s[2*XLEN-1:XLEN];
    end else begin
      fix_s = fixed_s[XLEN-1:0];
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = MD_IDLE;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start) begin
            state_s = special_s ? MD_FIXUP : MD_CALC;
          end else begin
            state_s = MD_IDLE;
          end
        end
        MD_CALC: begin
          if (cnt_r == CNT_LAST) begin
            state_s = MD_FIXUP;
          end else begin
            state_s = MD_CALC;
          end
        end
        MD_FIXUP: state_s = MD_DONE;
        MD_DONE:  state_s = MD_IDLE;
        default:  state_s = MD_IDLE;
      endcase
    end
  end

  // State register, operand capture, iteration datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= MD_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      op_r      <= 3'b000;
      opd_r     <= ZERO_X;
      lo_r      <= ZERO_X;
      hi_r      <= ZERO_X;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= ZERO_X;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != MD_IDLE);
      done_r  <= 1'b0;
      case (state_r)
        MD_IDLE: begin
          if (start && !flush) begin
            op_r  <= op;
            cnt_r <= {CNT_W{1'b0}};
            if (special_s) begin
              // Preload the architectural answer; fixup passes it through unsigned.
              lo_r      <= div_zero_s ? ONES_X : MIN_X;
              hi_r      <= div_zero_s ? rs1 : ZERO_X;
              opd_r     <= ZERO_X;
              neg_res_r <= 1'b0;
              neg_rem_r <= 1'b0;
            end else if (op[2]) begin
              lo_r      <= mag1_s;
              opd_r     <= mag2_s;
              hi_r      <= ZERO_X;
              neg_res_r <= sign1_s ^ sign2_s;
              neg_rem_r <= sign1_s;
            end else begin
              lo_r      <= mag2_s;
              opd_r     <= mag1_s;
              hi_r      <= ZERO_X;
              neg_res_r <= sign1_s ^ sign2_s;
              neg_rem_r <= 1'b0;
            end
          end
        end
        MD_CALC: begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (op_r[2]) begin
            if (!diff_s[XLEN]) begin
              hi_r <= diff_s[XLEN-1:0];
              lo_r <= {lo_r[XLEN-2:0], 1'b1};
            end else begin
              hi_r <= shifted_s[XLEN-1:0];
              lo_r <= {lo_r[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_r <= mul_sum_s[XLEN:1];
            lo_r <= {mul_sum_s[0], lo_r[XLEN-1:1]};
          end
        end
        MD_FIXUP: begin
          if (!flush) begin
            result_r <= fix_s;
            done_r   <= 1'b1;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed cases use
// hand-derived constants; random cases use a plain-arithmetic reference.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  // Reference: RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    logic [31:0]     r;
    sa = $signed(a); sb = $signed(b);
    ua = {32'd0, a}; ub = {32'd0, b};
    r  = 32'd0;
    case (o)
      3'd0: begin pu = ua * ub; r = pu[31:0]; end
      3'd1: begin ps = sa * sb; r = ps[63:32]; end
      3'd2: begin ps = sa * longint'(ub); r = ps[63:32]; end
      3'd3: begin pu = ua * ub; r = pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin ps = sa / sb; r = ps[31:0]; end
      end
      3'd5: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else r = a / b;
      end
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin ps = sa % sb; r = ps[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 32'd0)) return 2;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Launch one op and follow it to completion. lat = cycle offset of done
  // (-1 if none within the bound). With poke set, operands/op are scrambled
  // and an extra start is raised while busy.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke,
                       output int lat, output logic [31:0] res, output bit busy_ok, output bit tail_ok);
    lat = -1; res = 32'd0; busy_ok = 1'b1; tail_ok = 1'b1;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = k; res = result;
        break;
      end
      if (poke) begin
        rs1 = $urandom; rs2 = $urandom; op = 3'($urandom_range(0, 7));
        start = (k == 5);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (lat > 0) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0 || result !== res) tail_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{F3_MUL, F3_MULHU, F3_MULH, F3_MULHSU};
    logic [31:0] as  [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
    int lat; logic [31:0] res; bit bok, tok;
    for (int i = 0; i < 4; i++) begin
      // First case also scrambles inputs and raises start mid-operation.
      do_op(ops[i], as[i], bs[i], (i == 0), lat, res, bok, tok);
      checks++; if (res !== exps[i]) begin errors++; $display("FAIL mul%0d_result: got %h expected %h", i, res, exps[i]); end
      checks++; if (lat != 34) begin errors++; $display("FAIL mul%0d_latency: got %0d expected 34", i, lat); end
      checks++; if (!bok || !tok) begin errors++; $display("FAIL mul%0d_busy: busy_ok %b tail_ok %b expected 1 1", i, bok, tok); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
    logic [31:0] as  [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20};
    logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd3, 32'd2};
    int lat; logic [31:0] res; bit bok, tok;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], 32'd6, 1'b0, lat, res, bok, tok);
      checks++; if (res !== exps[i]) begin errors++; $display("FAIL div%0d_result: got %h expected %h", i, res, exps[i]); end
      checks++; if (lat != 34 || !bok || !tok) begin errors++; $display("FAIL div%0d_timing: got lat %0d busy_ok %b tail_ok %b expected 34 1 1", i, lat, bok, tok); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{F3_DIVU, F3_REM, F3_DIV, F3_REM};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lat; logic [31:0] res; bit bok, tok;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], 1'b0, lat, res, bok, tok);
      checks++; if (res !== exps[i]) begin errors++; $display("FAIL special%0d_result: got %h expected %h", i, res, exps[i]); end
      checks++; if (lat != 2 || !bok || !tok) begin errors++; $display("FAIL special%0d_timing: got lat %0d busy_ok %b tail_ok %b expected 2 1 1", i, lat, bok, tok); end
    end
  endtask

  task automatic test_flush();
    int pulses = 0;
    logic [31:0] prior = 32'd0;   // last completed op was REM 0x80000000 / -1
    @(negedge clk);
    op = F3_DIV; rs1 = 32'hFFFF_FFEC; rs2 = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;                  // cycle t+10
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL flush_done: got %0d pulses expected 0", pulses); end
    checks++; if (result !== prior) begin errors++; $display("FAIL flush_result: got %h expected %h", result, prior); end
    // flush and start together in IDLE: nothing launches.
    @(negedge clk);
    op = F3_MUL; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; bit bok, tok;
    @(negedge clk);
    op = F3_MUL; rs1 = 32'h1234_5678; rs2 = 32'h0000_9ABC; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL reset_mid: got busy %b done %b result %h expected 0 0 0", busy, done, result);
    end
    do_op(F3_MUL, 32'd3, 32'd4, 1'b0, lat, res, bok, tok);
    checks++; if (res !== 32'd12 || lat != 34) begin errors++; $display("FAIL reset_mid_mul: got %h at %0d expected 0000000c at 34", res, lat); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [3] = '{F3_REMU, F3_MULHSU, F3_DIV};
    logic [31:0] as  [3] = '{32'd77, 32'h8000_0000, 32'd100};
    logic [31:0] bs  [3] = '{32'd0, 32'd3, 32'hFFFF_FFF9};
    int lat; logic [31:0] res; bit bok, tok;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], as[i], bs[i], 1'b0, lat, res, bok, tok);
      checks++; if (res !== ref_model(ops[i], as[i], bs[i]) || lat != exp_latency(ops[i], as[i], bs[i])) begin
        errors++; $display("FAIL b2b%0d: got %h at %0d expected %h at %0d", i, res, lat, ref_model(ops[i], as[i], bs[i]), exp_latency(ops[i], as[i], bs[i]));
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] res, a, b, e; logic [2:0] o; bit bok, tok;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7)); a = pick(); b = pick();
      e = ref_model(o, a, b);
      do_op(o, a, b, bit'($urandom_range(0, 1)), lat, res, bok, tok);
      checks++; if (res !== e) begin errors++; $display("FAIL rand%0d_result: op %0d a %h b %h got %h expected %h", i, o, a, b, res, e); end
      checks++; if (lat != exp_latency(o, a, b) || !bok || !tok) begin
        errors++; $display("FAIL rand%0d_timing: got lat %0d busy_ok %b tail_ok %b expected %0d 1 1", i, lat, bok, tok, exp_latency(o, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execute unit in the EX stage, parallel to the ALU. It consumes the same func3-encoded operation select the decode path already produces for M-extension instructions (func7 = 0000001). It runs a fixed-latency shift-add multiply or restoring divide over XLEN cycles. While running, it holds `busy` so the hazard unit stalls IF/ID/EX, then pulses `done` with the result for EX/MEM capture.

## Interface
- XLEN, 32, operand/result width; the iteration count equals XLEN.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- op  in  3  func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  dividend / multiplicand; captured on accepted start
- rs2  in  XLEN  divisor / multiplier; captured on accepted start
- flush  in  1  abort (branch mispredict / pipeline flush)
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; result valid in this cycle
- result  out  XLEN  registered; holds last value until the next done

## Operation
- States:
  - IDLE → CALC on start && !flush (normal case).
  - IDLE → FIXUP on start && !flush && special case.
  - CALC → FIXUP when the iteration counter reaches XLEN−1.
  - FIXUP → DONE.
  - DONE → IDLE.
- Operand capture on accepted start:
  - Signed ops latch absolute values and the sign flags. Signed ops: MULH (both operands), MULHSU (rs1 only), DIV/REM (both).
  - Unsigned ops latch operands as-is.
- Multiply: 2·XLEN-bit accumulator, shift-add on magnitudes, one multiplier bit per CALC cycle.
- Divide: restoring, one quotient bit per cycle; remainder register is XLEN+1 bits for the trial subtract.
- FIXUP:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the dividend and divisor signs differ.
  - Give the remainder the dividend's sign.
  - Select the output: MUL = low half; MULH/MULHSU/MULHU = high half; DIV/DIVU = quotient; REM/REMU = remainder.
- Special cases, detected in IDLE, skip CALC:
  - Divide by zero: quotient = all ones (signed and unsigned); remainder = rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- start while busy: ignored; no queuing.
- flush in any state: next state IDLE, no done, result unchanged. flush and start in the same IDLE cycle: flush wins, nothing launched.
- rst: state IDLE, counter 0, busy = 0, done = 0, result = 0; a mid-operation reset discards all work.

## Timing
- Accepted start at cycle t:
  - Normal path: CALC during t+1 … t+XLEN; FIXUP at t+XLEN+1; DONE (done = 1, result valid) at t+XLEN+2; IDLE at t+XLEN+3. For XLEN = 32, done is at t+34.
  - Special-case path: FIXUP at t+1, done at t+2.
- busy is high from t+1 through the DONE cycle inclusive and drops in the cycle after done. Back-to-back start is therefore accepted at t+XLEN+3 at the earliest.
- done is exactly one cycle wide and never asserted without a preceding accepted start.
- Operands are not sampled after t; changes on rs1/rs2/op during busy have no effect.

## Structure
- In the shared defines include:
  - the M-extension func3 codes (`F3_MUL` … `F3_REMU`)
  - the func7 M-extension code
  - the state encodings (`MD_IDLE`, `MD_CALC`, `MD_FIXUP`, `MD_DONE`)
- No sub-module. Datapath and FSM stay flat; conditional negation is a single inline expression reused for the product, quotient and remainder.
- Decode of func7 = 0000001 into start stays in the control path, not in this block.

## Test plan
- MUL 7 × −3 (rs1 = 7, rs2 = 0xFFFFFFFD) → done at t+34, result = 0xFFFFFFEB; busy high t+1…t+34.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20 / 6 → 0xFFFFFFFD; REM −20 / 6 → 0xFFFFFFFE; DIVU 20 / 6 → 3; REMU 20 / 6 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF at t+2; REM 5 / 0 → 5; DIV 0x80000000 / −1 → 0x80000000, REM → 0, both done at t+2.
- Flush at t+10 of a DIV → busy low at t+11, no done pulse, result keeps its prior value. A start issued at t+5 mid-operation is ignored.
- rst asserted mid-CALC → next cycle busy = 0, done = 0, result = 0. A fresh MUL 3 × 4 then returns 12 at t+34.
